// File: rtl/sockit_spi_pkg.sv
// Shared constants and width helpers for the SPI core handshake blocks.
package sockit_spi_pkg;

    // Default configuration: four producer channels, three tokens deep each.
    localparam int SOCKIT_SPI_DEF_CHN = 4;
    localparam int SOCKIT_SPI_DEF_DPT = 3;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int sockit_spi_clog2(input int val);
        int res;
        res = 0;
        for (int v = val - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Channel select width; always at least one bit, even for one channel.
    function automatic int sockit_spi_slw(input int chn);
        return (chn < 2) ? 1 : sockit_spi_clog2(chn);
    endfunction

    // Counter width able to hold 0..dpt.
    function automatic int sockit_spi_cnw(input int dpt);
        return sockit_spi_clog2(dpt + 1);
    endfunction

endpackage

// File: rtl/sockit_spi_rra.sv
// Combinational round-robin search: returns the first set request bit,
// scanning cyclically from ptr+1 (wrapping from CHN-1 to 0).
module sockit_spi_rra
    import sockit_spi_pkg::*;
#(
    parameter int CHN = SOCKIT_SPI_DEF_CHN,
    localparam int SLW = sockit_spi_slw(CHN)
)(
    input  logic [CHN-1:0] req,
    input  logic [SLW-1:0] ptr,
    output logic [SLW-1:0] idx,
    output logic           vld
);

    // Outer loop walks priority order, so the first hit is the winner.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int k = 0; k < CHN; k++) begin
            for (int j = 0; j < CHN; j++) begin
                if (!vld && req[j] && (j == ((int'(ptr) + 1 + k) % CHN))) begin
                    vld = 1'b1;
                    idx = SLW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/sockit_spi_hsk.sv
// Multi-channel request/grant token buffer between the register/bus side
// and the serializer. Optional level output: define SOCKIT_SPI_HSK_LVL_EN.
//
// Handshake: on every port a transfer happens in exactly the cycles where
// req and grt are both 1. A req seen while grt is low is dropped with no
// side effect. Every grt is a register, so no grt depends combinationally
// on any req.
module sockit_spi_hsk
    import sockit_spi_pkg::*;
#(
    parameter int CHN = SOCKIT_SPI_DEF_CHN,
    parameter int DPT = SOCKIT_SPI_DEF_DPT,
    localparam int SLW = sockit_spi_slw(CHN),
    localparam int CNW = sockit_spi_cnw(DPT)
)(
    input  logic               hsk_clk,
    input  logic               hsk_rst_n,
    input  logic [CHN-1:0]     cda_req,
    output logic [CHN-1:0]     cda_grt,
    input  logic               cdb_req,
    output logic               cdb_grt,
    output logic [SLW-1:0]     cdb_sel
`ifdef SOCKIT_SPI_HSK_LVL_EN
    ,
    output logic [CHN*CNW-1:0] cda_lvl
`endif
);

    logic [CNW-1:0] cnt     [CHN];
    logic [CNW-1:0] cnt_nxt [CHN];
    logic [CHN-1:0] dep;
    logic [CHN-1:0] wd_hit;
    logic [CHN-1:0] busy_nxt;
    logic [CHN-1:0] grt_nxt;
    logic           wd;
    logic [SLW-1:0] ptr;
    logic [SLW-1:0] ptr_nxt;
    logic [SLW-1:0] sel_idx;
    logic           sel_vld;

    assign dep     = cda_req & cda_grt;
    assign wd      = cdb_req & cdb_grt;
    assign ptr_nxt = wd ? cdb_sel : ptr;

    // Post-transfer counter values; a deposit and a withdrawal on the same
    // channel cancel out. Grants are derived from these so the registered
    // grant already reflects this cycle's transfers.
    always_comb begin
        for (int i = 0; i < CHN; i++) begin
            wd_hit[i]  = wd && (cdb_sel == SLW'(i));
            cnt_nxt[i] = cnt[i];
            if (dep[i] && !wd_hit[i]) begin
                cnt_nxt[i] = cnt[i] + CNW'(1);
            end else if (!dep[i] && wd_hit[i]) begin
                cnt_nxt[i] = cnt[i] - CNW'(1);
            end
            busy_nxt[i] = (cnt_nxt[i] != '0);
            grt_nxt[i]  = (cnt_nxt[i] != CNW'(DPT));
        end
    end

    sockit_spi_rra #(
        .CHN (CHN)
    ) u_rra (
        .req (busy_nxt),
        .ptr (ptr_nxt),
        .idx (sel_idx),
        .vld (sel_vld)
    );

    // Counters, round-robin pointer and all grants; reset discards tokens.
    always_ff @(posedge hsk_clk or negedge hsk_rst_n) begin
        if (!hsk_rst_n) begin
            for (int i = 0; i < CHN; i++) begin
                cnt[i] <= '0;
            end
            ptr     <= SLW'(CHN - 1);
            cda_grt <= '0;
            cdb_grt <= 1'b0;
            cdb_sel <= '0;
        end else begin
            for (int i = 0; i < CHN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            ptr     <= ptr_nxt;
            cda_grt <= grt_nxt;
            cdb_grt <= |busy_nxt;
            if (sel_vld) begin
                cdb_sel <= sel_idx;
            end
        end
    end

`ifdef SOCKIT_SPI_HSK_LVL_EN
    // Expose registered fill levels for the software status registers.
    always_comb begin
        cda_lvl = '0;
        for (int i = 0; i < CHN; i++) begin
            cda_lvl[i*CNW +: CNW] = cnt[i];
        end
    end
`else
    // Without the level port the counters stay internal.
`endif

endmodule

// File: tb/tb_sockit_spi_hsk.sv
// Directed bench for sockit_spi_hsk (CHN=4, DPT=3) with a token-count
// reference model compared every cycle, plus hand-computed spot checks.
module tb_sockit_spi_hsk;

    localparam int CHN = 4;
    localparam int DPT = 3;

    logic           hsk_clk;
    logic           hsk_rst_n;
    logic [CHN-1:0] cda_req;
    logic [CHN-1:0] cda_grt;
    logic           cdb_req;
    logic           cdb_grt;
    logic [1:0]     cdb_sel;
`ifdef SOCKIT_SPI_HSK_LVL_EN
    logic [7:0]     cda_lvl;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int             m_cnt [CHN];
    int             m_ptr;
    logic [CHN-1:0] m_cda;
    logic           m_cdb;
    int             m_sel;

    sockit_spi_hsk #(
        .CHN (CHN),
        .DPT (DPT)
    ) dut (
        .hsk_clk   (hsk_clk),
        .hsk_rst_n (hsk_rst_n),
        .cda_req   (cda_req),
        .cda_grt   (cda_grt),
        .cdb_req   (cdb_req),
        .cdb_grt   (cdb_grt),
        .cdb_sel   (cdb_sel)
`ifdef SOCKIT_SPI_HSK_LVL_EN
        ,
        .cda_lvl   (cda_lvl)
`endif
    );

    // clock
    initial begin
        hsk_clk = 1'b0;
        forever #5 hsk_clk = ~hsk_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Token-count model: transfers happen where the model's own grant was
    // high; grants and the next selection follow from the resulting counts.
    always @(posedge hsk_clk or negedge hsk_rst_n) begin
        if (!hsk_rst_n) begin
            for (int i = 0; i < CHN; i++) m_cnt[i] = 0;
            m_ptr = CHN - 1;
            m_cda = '0;
            m_cdb = 1'b0;
            m_sel = 0;
        end else begin
            if (cdb_req && m_cdb) begin
                m_cnt[m_sel] -= 1;
                m_ptr = m_sel;
            end
            for (int i = 0; i < CHN; i++) begin
                if (cda_req[i] && m_cda[i]) m_cnt[i] += 1;
            end
            m_cdb = 1'b0;
            for (int i = 0; i < CHN; i++) begin
                m_cda[i] = (m_cnt[i] != DPT);
                if (m_cnt[i] > 0) m_cdb = 1'b1;
            end
            for (int s = 1; s <= CHN; s++) begin
                if (m_cnt[(m_ptr + s) % CHN] > 0) begin
                    m_sel = (m_ptr + s) % CHN;
                    break;
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge hsk_clk) begin
        check("cyc_cda_grt", cda_grt, m_cda);
        check("cyc_cdb_grt", cdb_grt, m_cdb);
        check("cyc_cdb_sel", cdb_sel, m_sel);
`ifdef SOCKIT_SPI_HSK_LVL_EN
        begin
            logic [7:0] lvl_exp;
            for (int i = 0; i < CHN; i++) lvl_exp[i*2 +: 2] = 2'(m_cnt[i]);
            check("cyc_cda_lvl", cda_lvl, lvl_exp);
        end
`endif
    end

    // driver: apply one cycle of inputs on the falling edge
    task automatic tick(input logic [CHN-1:0] a, input logic b);
        @(negedge hsk_clk);
        cda_req = a;
        cdb_req = b;
    endtask

    // assert reset mid-cycle, check immediate clear, release on a falling edge
    task automatic reset_pulse();
        @(negedge hsk_clk);
        #2;
        hsk_rst_n = 1'b0;
        cda_req   = '0;
        cdb_req   = 1'b0;
        #1;
        check("rst_imm_cda", cda_grt, 0);
        check("rst_imm_cdb", cdb_grt, 0);
        check("rst_imm_sel", cdb_sel, 0);
        repeat (2) @(negedge hsk_clk);
        hsk_rst_n = 1'b1;
    endtask

    initial begin
        hsk_rst_n = 1'b0;
        cda_req   = '0;
        cdb_req   = 1'b0;
        repeat (2) @(negedge hsk_clk);
        check("rst_cda", cda_grt, 0);
        check("rst_cdb", cdb_grt, 0);
        check("rst_sel", cdb_sel, 0);
        hsk_rst_n = 1'b1;

        // idle after release
        tick(4'b0000, 1'b0);
        check("rel_cda", cda_grt, 4'b1111);
        check("rel_cdb", cdb_grt, 0);
        check("rel_sel", cdb_sel, 0);
        repeat (3) tick(4'b0000, 1'b0);
        check("idle_cda", cda_grt, 4'b1111);

        // fill channel 2, fourth deposit refused
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        check("dep_lat_cdb", cdb_grt, 1);
        check("dep_lat_sel", cdb_sel, 2);
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        check("full_cda", cda_grt, 4'b1011);
        tick(4'b0000, 1'b0);
        check("full_hold_cda", cda_grt, 4'b1011);
        check("full_cnt2", m_cnt[2], 3);
        repeat (3) tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        check("drain_cdb", cdb_grt, 0);
        check("drain_cda", cda_grt, 4'b1111);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        check("ign_cdb", cdb_grt, 0);

        // one token per channel, drained in round-robin order
        reset_pulse();
        tick(4'b1111, 1'b0);
        check("rr_pre_cda", cda_grt, 4'b1111);
        tick(4'b0000, 1'b1);
        check("rr_sel0", cdb_sel, 0);
        check("rr_cdb", cdb_grt, 1);
        tick(4'b0000, 1'b1);
        check("rr_sel1", cdb_sel, 1);
        tick(4'b0000, 1'b1);
        check("rr_sel2", cdb_sel, 2);
        tick(4'b0000, 1'b1);
        check("rr_sel3", cdb_sel, 3);
        tick(4'b0000, 1'b0);
        check("rr_empty_cdb", cdb_grt, 0);
        check("rr_empty_cda", cda_grt, 4'b1111);

        // channel 1 full, then simultaneous deposit and withdrawal
        repeat (3) tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b1);
        check("ch1_full_cda", cda_grt, 4'b1101);
        check("ch1_sel", cdb_sel, 1);
        tick(4'b0010, 1'b1);
        check("wd_lat_cda", cda_grt, 4'b1111);
        tick(4'b0000, 1'b0);
        check("both_cda", cda_grt, 4'b1111);
        check("both_cnt1", m_cnt[1], 2);
        check("both_ptr", m_ptr, 1);
        check("both_sel", cdb_sel, 1);
        repeat (2) tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        check("ch1_drain_cdb", cdb_grt, 0);

        // wrap-around: ptr=2, tokens in channels 3 and 0
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b1);
        tick(4'b1001, 1'b0);
        tick(4'b0000, 1'b1);
        check("wrap_ptr", m_ptr, 2);
        check("wrap_sel3", cdb_sel, 3);
        tick(4'b0000, 1'b1);
        check("wrap_sel0", cdb_sel, 0);
        tick(4'b0000, 1'b0);
        check("wrap_cdb", cdb_grt, 0);
        check("wrap_ptr0", m_ptr, 0);

        // last token withdrawn while another channel deposits
        tick(4'b0001, 1'b0);
        tick(4'b0100, 1'b1);
        tick(4'b0000, 1'b0);
        check("empty_bnd_cdb", cdb_grt, 1);
        check("empty_bnd_sel", cdb_sel, 2);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        check("empty_cdb", cdb_grt, 0);

        // reset with two tokens pending
        tick(4'b0011, 1'b0);
        tick(4'b0000, 1'b0);
        check("pend_cdb", cdb_grt, 1);
        check("pend_cnt0", m_cnt[0], 1);
        check("pend_cnt1", m_cnt[1], 1);
        reset_pulse();
        tick(4'b0000, 1'b0);
        check("post_rst_cda", cda_grt, 4'b1111);
        check("post_rst_cdb", cdb_grt, 0);
        check("post_rst_sel", cdb_sel, 0);
`ifdef SOCKIT_SPI_HSK_LVL_EN
        check("post_rst_lvl", cda_lvl, 0);
`endif

        // mixed traffic checked by the model
        repeat (200) tick(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
